// File: rtl/pin_cond_pkg.sv
// Shared defaults and helpers for the pin conditioner.
package pin_cond_pkg;

    localparam int unsigned CH_DEFAULT      = 8;
    localparam int unsigned DEB_LEN_DEFAULT = 4;

    // Debounce counter width, wide enough to hold DEB_LEN.
    function automatic int unsigned cnt_width(input int unsigned deb_len);
        return (deb_len < 1) ? 1 : $clog2(deb_len + 1);
    endfunction

endpackage

// File: rtl/pin_cond_chan.sv
// One conditioned channel: 2-flop synchroniser, optional debounce, sticky edge flags.
// Debounce is built only when PIN_COND_DEBOUNCE_EN is defined.
module pin_cond_chan
    import pin_cond_pkg::*;
`ifdef PIN_COND_DEBOUNCE_EN
#(
    parameter int unsigned DEB_LEN = DEB_LEN_DEFAULT
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic pin,
    input  logic invert,
    input  logic evt_clr,
    output logic level,
    output logic rise_evt,
    output logic fall_evt
);

    logic sync1, sync2, stable, stable_nxt;
    logic rise_set, fall_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef PIN_COND_DEBOUNCE_EN
    localparam int unsigned   CW   = cnt_width(DEB_LEN);
    localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);

    logic [CW-1:0] cnt, cnt_nxt;

    // Any return to the stable level restarts the count, so short pulses vanish.
    always_comb begin
        cnt_nxt    = cnt;
        stable_nxt = stable;
        if (ena) begin
            if (sync2 == stable) begin
                cnt_nxt = '0;
            end else if (cnt == LAST) begin
                stable_nxt = sync2;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end
`else
    assign stable_nxt = ena ? sync2 : stable;
`endif

    assign rise_set = ~stable &  stable_nxt;
    assign fall_set =  stable & ~stable_nxt;

    // A set landing in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= 1'b0;
            rise_evt <= 1'b0;
            fall_evt <= 1'b0;
        end else begin
            stable   <= stable_nxt;
            rise_evt <= rise_set | (rise_evt & ~evt_clr);
            fall_evt <= fall_set | (fall_evt & ~evt_clr);
        end
    end

    assign level = stable ^ invert;

endmodule

// File: rtl/pin_conditioner.sv
// Multi-channel input pin conditioner: synchronise, debounce, detect edges, raise irq.
// Debounce enabled by defining PIN_COND_DEBOUNCE_EN; otherwise plain resync with 3-edge latency.
module pin_conditioner
    import pin_cond_pkg::*;
#(
    parameter int unsigned CH      = CH_DEFAULT,
    parameter int unsigned DEB_LEN = DEB_LEN_DEFAULT
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [CH-1:0] pin_in,
    input  logic [CH-1:0] invert,
    input  logic [CH-1:0] evt_clr,
    output logic [CH-1:0] pin_out,
    output logic [CH-1:0] rise_evt,
    output logic [CH-1:0] fall_evt,
    output logic          irq
);

    if (CH < 1 || CH > 32 || DEB_LEN < 1 || DEB_LEN > 255) begin : g_bad_cfg
        $error("pin_conditioner: CH or DEB_LEN out of range");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
`ifdef PIN_COND_DEBOUNCE_EN
        pin_cond_chan #(.DEB_LEN(DEB_LEN)) u_chan (
`else
        pin_cond_chan u_chan (
`endif
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .pin      (pin_in[i]),
            .invert   (invert[i]),
            .evt_clr  (evt_clr[i]),
            .level    (pin_out[i]),
            .rise_evt (rise_evt[i]),
            .fall_evt (fall_evt[i])
        );
    end

    assign irq = |(rise_evt | fall_evt);

endmodule

// File: doc/pin_conditioner.md
PIN_CONDITIONER -- requirements
Module: pin_conditioner

Interface
REQ-001 SHALL have parameter CH, default 8, meaning number of independent input channels (1..32).
REQ-002 SHALL have parameter DEB_LEN, default 4, meaning consecutive stable cycles required before accepting a level change (1..255).
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the port ena, input, 1 bit: high = conditioning active; low = debounce state and events frozen.
REQ-006 SHALL have the port pin_in, input, CH bits: raw asynchronous pad levels.
REQ-007 SHALL have the port invert, input, CH bits: per-channel output polarity, quasi-static.
REQ-008 SHALL have the port evt_clr, input, CH bits: per-channel single-cycle clear of both event flags.
REQ-009 SHALL have the port pin_out, output, CH bits: conditioned level XOR invert.
REQ-010 SHALL have the port rise_evt, output, CH bits: sticky flag, conditioned level went 0->1 (pre-invert).
REQ-011 SHALL have the port fall_evt, output, CH bits: sticky flag, conditioned level went 1->0 (pre-invert).
REQ-012 SHALL have the port irq, output, 1 bit: OR of all rise_evt and fall_evt bits, combinational from registers.

Function
REQ-013 SHALL pass each pin_in bit through a two-flop synchroniser (sync1, sync2), always clocked regardless of ena.
REQ-014 SHALL hold per channel a registered stable level and a debounce counter of width clog2(DEB_LEN+1).
REQ-015 SHALL, with ena high and sync2 == stable, clear the counter.
REQ-016 SHALL, with ena high and sync2 != stable and counter < DEB_LEN-1, increment the counter.
REQ-017 SHALL, with ena high and sync2 != stable and counter == DEB_LEN-1, load stable from sync2 and clear the counter.
REQ-018 SHALL give latency from a pin_in change to pin_out change of exactly 2+DEB_LEN rising edges for a clean step.
REQ-019 SHALL reject any pulse held fewer than DEB_LEN cycles at sync2 (counter clears, no stable change, no event).
REQ-020 SHALL, in the cycle stable is loaded 0->1, set rise_evt; on 1->0, set fall_evt.
REQ-021 SHALL clear both event flags of channel i on evt_clr[i]; a simultaneous set and clear SHALL leave the flag set.
REQ-022 SHALL, with ena low, hold counter, stable and event flags unchanged (evt_clr still honoured).
REQ-023 SHALL drive pin_out = stable XOR invert combinationally; toggling invert SHALL NOT set any event.

Reset
REQ-024 SHALL on rst_n low asynchronously clear sync1, sync2, stable, counters, rise_evt and fall_evt.
REQ-025 SHALL therefore present pin_out = invert, irq = 0 during and after reset.
REQ-026 SHALL discard any in-progress debounce count on reset assertion mid-operation; no event SHALL result.

Configuration
REQ-027 SHALL honour macro PIN_COND_DEBOUNCE_EN: defined, debounce per REQ-014..REQ-019.
REQ-028 SHALL, without PIN_COND_DEBOUNCE_EN, omit counters and load stable from sync2 every ena-high cycle (latency 3 edges); DEB_LEN then unused.

Structure
REQ-029 SHALL place default CH, default DEB_LEN and the counter-width function in package pin_cond_pkg.
REQ-030 SHALL implement one channel (sync, counter, stable, events) in sub-module pin_cond_chan, instantiated CH times by generate.

Verification
REQ-031 SHALL verify step: CH=8, DEB_LEN=4, pin_in[0] 0->1 -> pin_out[0] rises at edge 6, rise_evt[0]=1, irq=1.
REQ-032 SHALL verify glitch: pin_in[3] high for 3 cycles then low -> pin_out[3], rise_evt[3], irq unchanged at 0.
REQ-033 SHALL verify clear race: evt_clr[0] asserted in the cycle fall_evt[0] sets -> fall_evt[0]=1 afterwards.
REQ-034 SHALL verify freeze: ena=0 while pin_in[1] steps -> no change for 20 cycles; ena=1 -> pin_out[1] changes 4 edges later.
REQ-035 SHALL verify reset mid-count: rst_n low at counter=2 -> all outputs reset, pin_out=invert=8'hA5, irq=0.
REQ-036 SHALL verify macro off: pin_in[7] 1-cycle pulse -> pin_out[7] pulses 3 edges later, rise_evt[7] and fall_evt[7] both set.
